// File: rtl/timer_counter_pkg.sv
// Shared register offsets, CTRL bit positions and FSM encodings for timer_counter.
// Consumed by the timer instances that sit in the TC1/TC2 windows beside the data memory.
package timer_counter_pkg;

  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;

  localparam int TC_EN      = 0;
  localparam int TC_MODE_LO = 1;
  localparam int TC_MODE_HI = 2;
  localparam int TC_IM      = 3;

  localparam logic [1:0] TC_MODE_RELOAD = 2'd1;

  typedef enum logic [1:0] {
    TC_IDLE = 2'd0,
    TC_LOAD = 2'd1,
    TC_CNT  = 2'd2,
    TC_INT  = 2'd3
  } tc_state_e;

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped 32-bit down-counting timer with one interrupt line.
// Auto-reload mode exists only when TIMER_AUTO_RELOAD_EN is defined; otherwise every mode is one-shot.
//
// state   | meaning
// IDLE    | stopped, waiting for CTRL.Enable
// LOAD    | copy registered PRESET into COUNT
// CNT     | counting down while Enable stays set
// INT     | terminal count reached, irq_flag set
module timer_counter
  import timer_counter_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd_o,
  output logic        irq_o
);

  tc_state_e   state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        flag_q, flag_d;

  logic [1:0]  reg_sel;
  logic        wr_ctrl, wr_preset;
  logic        enable, auto_reload, at_terminal;
  logic        unused_addr_bits;

  assign reg_sel          = addr_i[3:2];
  assign unused_addr_bits = ^{addr_i[31:4], addr_i[1:0]};
  assign wr_ctrl          = we_i && (reg_sel == TC_CTRL);
  assign wr_preset        = we_i && (reg_sel == TC_PRESET);
  assign enable           = ctrl_q[TC_EN];
  assign at_terminal      = (count_q <= 32'd1);

`ifdef TIMER_AUTO_RELOAD_EN
  assign auto_reload = (ctrl_q[TC_MODE_HI:TC_MODE_LO] == TC_MODE_RELOAD);
`else
  assign auto_reload = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= TC_IDLE;
      ctrl_q   <= 4'd0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TC_IDLE: if (enable) state_d = TC_LOAD;
      TC_LOAD: state_d = TC_CNT;
      TC_CNT: begin
        if (!enable)          state_d = TC_IDLE;
        else if (at_terminal) state_d = TC_INT;
      end
      TC_INT: begin
`ifdef TIMER_AUTO_RELOAD_EN
        state_d = auto_reload ? TC_LOAD : TC_IDLE;
`else
        state_d = TC_IDLE;
`endif
      end
      default: state_d = TC_IDLE;
    endcase
  end

  // Register updates: CPU writes override the INT-state Enable clear, but a
  // flag set on the CNT->INT edge overrides the write-induced flag clear.
  always_comb begin
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;

    if (wr_ctrl || wr_preset) flag_d = 1'b0;

    unique case (state_q)
      TC_LOAD: count_d = preset_q;
      TC_CNT: begin
        if (enable) begin
          if (!at_terminal) begin
            count_d = count_q - 32'd1;
          end else begin
            count_d = 32'd0;
            flag_d  = 1'b1;
          end
        end
      end
      TC_INT: begin
        if (auto_reload) flag_d = 1'b0;
        else             ctrl_d[TC_EN] = 1'b0;
      end
      default: ;
    endcase

    if (wr_ctrl)   ctrl_d   = wd_i[3:0];
    if (wr_preset) preset_d = wd_i;
  end

  always_comb begin
    rd_o = 32'd0;
    unique case (reg_sel)
      TC_CTRL:   rd_o = {28'd0, ctrl_q};
      TC_PRESET: rd_o = preset_q;
      TC_COUNT:  rd_o = count_q;
      default:   rd_o = 32'd0;
    endcase
  end

  assign irq_o = ctrl_q[TC_IM] & flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: register access, one-shot, auto-reload, disable/re-enable,
// masked interrupt, zero preset, same-edge write priorities and asynchronous reset.
module tb_timer_counter;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PRESET = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;
  localparam logic [1:0] A_NONE   = 2'd3;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;

  int total = 0;
  int bad   = 0;

  timer_counter dut (
    .clk_i   (clk),
    .reset_i (reset),
    .addr_i  (addr),
    .we_i    (we),
    .wd_i    (wd),
    .rd_o    (rd),
    .irq_o   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = 32'h0000_7f00 + {28'd0, a, 2'b00};
    wd   = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we   = 1'b0;
  endtask

  task automatic rchk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = 32'h0000_7f00 + {28'd0, a, 2'b00};
    #1;
    chk(tag, rd, exp);
  endtask

  initial begin
    logic exp_irq;
    reset = 1'b0;
    we    = 1'b0;
    addr  = 32'h0000_7f00;
    wd    = 32'd0;
    #2;
    reset = 1'b1;
    #1;
    rchk("rst_ctrl", A_CTRL, 32'd0);
    rchk("rst_preset", A_PRESET, 32'd0);
    rchk("rst_count", A_COUNT, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // register access
    wr(A_CTRL, 32'hFFFF_FFF6);
    rchk("ctrl_mask", A_CTRL, 32'h0000_0006);
    wr(A_CTRL, 32'd0);
    wr(A_PRESET, 32'hA5A5_0003);
    rchk("preset_rw", A_PRESET, 32'hA5A5_0003);
    wr(A_COUNT, 32'h0000_0055);
    rchk("count_ro", A_COUNT, 32'd0);
    rchk("addr3_zero", A_NONE, 32'd0);

    // one-shot, PRESET=5, IM set
    wr(A_PRESET, 32'd5);
    wr(A_CTRL, 32'h9);
    tick(); tick();
    rchk("a_count_e2", A_COUNT, 32'd5);
    tick(); tick(); tick(); tick();
    rchk("a_count_e6", A_COUNT, 32'd1);
    chk("a_irq_e6", {31'd0, irq}, 32'd0);
    tick();
    rchk("a_count_e7", A_COUNT, 32'd0);
    chk("a_irq_e7", {31'd0, irq}, 32'd1);
    tick();
    rchk("a_ctrl_e8", A_CTRL, 32'h8);
    chk("a_irq_held", {31'd0, irq}, 32'd1);
    tick();
    chk("a_irq_held2", {31'd0, irq}, 32'd1);
    wr(A_CTRL, 32'h8);
    chk("a_irq_cleared", {31'd0, irq}, 32'd0);

    // mode 1, PRESET=3
    wr(A_PRESET, 32'd3);
    wr(A_CTRL, 32'hB);
    for (int k = 1; k <= 20; k++) begin
      tick();
`ifdef TIMER_AUTO_RELOAD_EN
      exp_irq = (k >= 5) && (k % 5 == 0);
`else
      exp_irq = (k >= 5);
`endif
      chk($sformatf("b_irq_k%0d", k), {31'd0, irq}, {31'd0, exp_irq});
    end
`ifdef TIMER_AUTO_RELOAD_EN
    rchk("b_ctrl", A_CTRL, 32'hB);
`else
    rchk("b_ctrl", A_CTRL, 32'hA);
`endif
    wr(A_CTRL, 32'd0);
    tick(); tick(); tick();
    chk("b_irq_off", {31'd0, irq}, 32'd0);

    // disable mid-count then re-enable
    wr(A_PRESET, 32'd10);
    wr(A_CTRL, 32'h1);
    tick(); tick(); tick(); tick(); tick();
    rchk("c_count_e5", A_COUNT, 32'd7);
    wr(A_CTRL, 32'd0);
    rchk("c_count_e6", A_COUNT, 32'd6);
    tick(); tick(); tick();
    rchk("c_count_hold", A_COUNT, 32'd6);
    wr(A_CTRL, 32'h1);
    tick();
    rchk("c_count_load", A_COUNT, 32'd6);
    tick();
    rchk("c_count_reload", A_COUNT, 32'd10);
    wr(A_CTRL, 32'd0);
    tick(); tick(); tick();

    // IM=0, PRESET=2
    wr(A_PRESET, 32'd2);
    wr(A_CTRL, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("d_irq_k%0d", k), {31'd0, irq}, 32'd0);
    end
    rchk("d_ctrl", A_CTRL, 32'd0);
    rchk("d_count", A_COUNT, 32'd0);
    wr(A_CTRL, 32'h8);
    chk("d_irq_im", {31'd0, irq}, 32'd0);
    tick();
    chk("d_irq_im2", {31'd0, irq}, 32'd0);
    wr(A_CTRL, 32'd0);

    // PRESET=0
    wr(A_PRESET, 32'd0);
    wr(A_CTRL, 32'h9);
    tick(); tick();
    chk("e_irq_e2", {31'd0, irq}, 32'd0);
    rchk("e_count_e2", A_COUNT, 32'd0);
    tick();
    chk("e_irq_e3", {31'd0, irq}, 32'd1);
    tick();
    rchk("e_ctrl_e4", A_CTRL, 32'h8);
    wr(A_PRESET, 32'd4);
    chk("e_irq_cleared", {31'd0, irq}, 32'd0);
    tick(); tick(); tick();
    rchk("e_count_idle", A_COUNT, 32'd0);
    chk("e_irq_idle", {31'd0, irq}, 32'd0);
    rchk("e_preset", A_PRESET, 32'd4);

    // PRESET write during CNT, fresh PRESET on re-enable
    wr(A_PRESET, 32'd8);
    wr(A_CTRL, 32'h9);
    tick(); tick();
    rchk("f_count_e2", A_COUNT, 32'd8);
    wr(A_PRESET, 32'd20);
    rchk("f_count_e3", A_COUNT, 32'd7);
    tick();
    rchk("f_count_e4", A_COUNT, 32'd6);
    wr(A_CTRL, 32'h8);
    rchk("f_count_e5", A_COUNT, 32'd5);
    tick();
    rchk("f_count_hold", A_COUNT, 32'd5);
    wr(A_CTRL, 32'h9);
    tick(); tick();
    rchk("f_count_fresh", A_COUNT, 32'd20);
    wr(A_CTRL, 32'd0);
    tick(); tick();

    // same-edge priorities
    wr(A_PRESET, 32'd2);
    wr(A_CTRL, 32'h9);
    tick(); tick(); tick();
    wr(A_PRESET, 32'd2);
    chk("g_set_wins", {31'd0, irq}, 32'd1);
    rchk("g_count_int", A_COUNT, 32'd0);
    wr(A_CTRL, 32'h9);
    rchk("g_ctrl_write_wins", A_CTRL, 32'h9);
    chk("g_irq_cleared", {31'd0, irq}, 32'd0);
    tick(); tick();
    rchk("g_count_restart", A_COUNT, 32'd2);
    wr(A_CTRL, 32'd0);
    tick(); tick(); tick();

    // asynchronous reset mid-count
    wr(A_PRESET, 32'd10);
    wr(A_CTRL, 32'h9);
    tick(); tick(); tick(); tick(); tick();
    rchk("h_count_pre", A_COUNT, 32'd7);
    reset = 1'b1;
    #1;
    rchk("h_count_rst", A_COUNT, 32'd0);
    rchk("h_ctrl_rst", A_CTRL, 32'd0);
    rchk("h_preset_rst", A_PRESET, 32'd0);
    chk("h_irq_rst", {31'd0, irq}, 32'd0);
    tick();
    reset = 1'b0;
    tick(); tick(); tick();
    rchk("h_count_after", A_COUNT, 32'd0);
    chk("h_irq_after", {31'd0, irq}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped 32-bit down-counting timer that sits directly behind the M-stage data-memory address decode. The decode forwards word stores and loads in the TC1 window (0x7f00–0x7f0b) or the TC2 window (0x7f10–0x7f1b) to one instance per window. Each instance drives one interrupt line into the CP0 hardware-interrupt inputs. The M stage already rejects non-word and COUNT-register stores with AdEL/AdES, so this block never sees them.

## Interface
Parameters: none.
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- addr  in  32  byte address from the M stage; only addr[3:2] is decoded (0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reads 0).
- we  in  1  write strobe, already qualified by the window decode.
- wd  in  32  store data.
- rd  out  32  combinational read of the register selected by addr[3:2].
- irq  out  1  interrupt request, defined as CTRL.IM & irq_flag.

## Operation
- CTRL register:
  - bit0 = Enable.
  - bits[2:1] = Mode: 0 = one-shot, 1 = auto-reload, 2 and 3 behave as 0.
  - bit3 = IM (interrupt mask).
  - bits[31:4] are not stored and read as 0.
- PRESET: full 32-bit read/write.
- COUNT: read-only. Writes are ignored.
- FSM states are IDLE, LOAD, CNT, INT. Transitions on each posedge:
  - IDLE: if Enable, go to LOAD.
  - LOAD: COUNT <= PRESET (the registered value), then go to CNT.
  - CNT, Enable = 0: go to IDLE; COUNT holds.
  - CNT, COUNT > 1: COUNT <= COUNT - 1.
  - CNT, COUNT ≤ 1: COUNT <= 0, irq_flag <= 1, go to INT.
  - INT, mode 0: Enable <= 0, go to IDLE; irq_flag stays set.
  - INT, mode 1: irq_flag <= 0, go to LOAD.
- Clearing irq_flag: any write to CTRL or PRESET clears it, except in the edge case listed below.
- Arithmetic: unsigned 32-bit. COUNT never wraps below 0.
- Boundary rules:
  - PRESET = 0 and PRESET = 1 both reach INT one cycle after LOAD.
  - A PRESET write during CNT does not alter the running COUNT. It takes effect at the next LOAD.
  - A CTRL write on the same edge as the INT-state Enable clear: the CPU write wins, for all CTRL bits.
  - A CTRL/PRESET write on the same edge irq_flag is set (CNT→INT): the set wins.
  - Disable then re-enable always restarts from LOAD, with a fresh PRESET.
  - Reset mid-count: everything returns to its reset values asynchronously. There is no pending interrupt afterwards.

## Timing
- Reset values: CTRL = 0, PRESET = 0, COUNT = 0, state = IDLE, irq_flag = 0, irq = 0, rd = 0 for addr 0/1/2.
- Register writes land at the posedge where we = 1. rd reflects the new value in the following cycle; rd has no added latency.
- If Enable is written at edge E: LOAD at E+1, COUNT = PRESET after E+2, irq rises after edge E+PRESET+2 (minimum E+3).
- Mode 0: irq is held high until software writes CTRL or PRESET.
- Mode 1: irq is a one-cycle pulse, repeating every PRESET+2 cycles (minimum 3).
- irq is combinational from registered state only, so it is glitch-free at the CP0 boundary.

## Configuration
- TIMER_AUTO_RELOAD_EN defined: mode 1 behaves as specified above.
- Undefined:
  - Mode bits remain writable and readable.
  - Every mode behaves as mode 0 (one-shot, Enable cleared, irq held).
  - The INT→LOAD path is not built.

## Structure
- The following go into the shared const.v:
  - the register offsets `TC_CTRL, `TC_PRESET, `TC_COUNT;
  - the CTRL bit indices `TC_EN, `TC_MODE_HI/LO, `TC_IM;
  - the state encodings `TC_IDLE, `TC_LOAD, `TC_CNT, `TC_INT.
- Single flat module with no sub-modules. The FSM and register file are small and tightly coupled.
- Two instances are placed beside M_DM; each gets we gated by its own window decode.

## Test plan
- Reset asserted mid-CNT with COUNT = 7: COUNT, CTRL, state and irq read 0 immediately, without waiting for a clock edge.
- PRESET = 5, CTRL = 0x9 (Enable, mode 0, IM) at edge E:
  - COUNT = 5 after E+2 and 0 after E+7;
  - irq = 1 from E+7;
  - CTRL reads 0x8 after E+8;
  - irq drops after the next CTRL write.
- PRESET = 3, CTRL = 0xB (mode 1): irq pulses exactly one cycle, every 5 cycles, for at least 3 periods. With the macro undefined, only one pulse occurs and irq stays high.
- PRESET = 10, Enable; write CTRL = 0 when COUNT = 6: COUNT stays 6. Then Enable again: COUNT reloads to 10 two edges later.
- IM = 0, mode 0, PRESET = 2: irq stays 0 throughout. Setting IM = 1 afterwards does not raise irq, because the CTRL write clears irq_flag.
- PRESET = 0 with Enable: irq after E+3. Then write PRESET = 4 during the one-shot's IDLE: irq drops and COUNT stays 0 until re-enabled.
